// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with a direct (latched index) mode and
// an autonomous scan mode that walks every output for DWELL cycles each.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | out of reset, b inactive, valid low until first load/scan
//   DIRECT | b shows decode of the last loaded (or last scanned) index
//   SCAN   | idx walks 0..2^N-1, each held DWELL cycles, wrap on 2^N-1->0
module decoder_nx2n_seq #(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      a,
    output logic [2**N-1:0]   b,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [W-1:0]  B_INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   dwell_cnt, dwell_cnt_nxt;
    logic [N-1:0]    idx_nxt;
    logic [W-1:0]    b_nxt;
    logic            valid_nxt;
    logic            wrap_nxt;

    function automatic logic [W-1:0] decode(input logic [N-1:0] i);
        logic [W-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            idx       <= '0;
            b         <= B_INACTIVE;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            idx       <= idx_nxt;
            b         <= b_nxt;
            valid     <= valid_nxt;
            wrap      <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dwell_cnt_nxt = dwell_cnt;
        idx_nxt       = idx;
        b_nxt         = b;
        valid_nxt     = valid;
        wrap_nxt      = 1'b0;

        if (en) begin
            if (!mode) begin
                state_nxt = DIRECT;
                if (load) begin
                    idx_nxt   = a;
                    b_nxt     = decode(a);
                    valid_nxt = 1'b1;
                end
            end else if (state != SCAN) begin
                // Entry edge always restarts the walk at 0; a coincident load is dropped.
                state_nxt     = SCAN;
                idx_nxt       = '0;
                b_nxt         = decode('0);
                valid_nxt     = 1'b1;
                dwell_cnt_nxt = '0;
            end else if (load) begin
                idx_nxt       = a;
                b_nxt         = decode(a);
                dwell_cnt_nxt = '0;
            end else if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt_nxt = '0;
                idx_nxt       = idx + N'(1);
                b_nxt         = decode(idx + N'(1));
                wrap_nxt      = (idx == {N{1'b1}});
            end else begin
                dwell_cnt_nxt = dwell_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed bench for decoder_nx2n_seq: default N=2/DWELL=4 instance plus an
// N=3/DWELL=1/ACTIVE_LOW=1 instance for the inverted, every-cycle scan.
module tb_decoder_nx2n_seq;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, load;
    logic [1:0] a;
    logic [3:0] b;
    logic [1:0] idx;
    logic       valid, wrap;

    logic       rst_n2, en2, mode2, load2;
    logic [2:0] a2;
    logic [7:0] b2;
    logic [2:0] idx2;
    logic       valid2, wrap2;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    decoder_nx2n_seq #(.N(2), .DWELL(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .a(a),
        .b(b), .idx(idx), .valid(valid), .wrap(wrap)
    );

    decoder_nx2n_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n2), .en(en2), .mode(mode2), .load(load2), .a(a2),
        .b(b2), .idx(idx2), .valid(valid2), .wrap(wrap2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en   = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 1));
            a    = 2'($urandom_range(0, 3));
            step();
        end
        vec_cnt++;
        if ({b, idx, valid, wrap} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
            miss_cnt++;
            $display("FAIL reset_state: got b=%b idx=%0d valid=%b wrap=%b, want b=0000 idx=0 valid=0 wrap=0",
                     b, idx, valid, wrap);
        end
        rst_n = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; a = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if (b !== 4'b0000 || valid !== 1'b0) begin
                miss_cnt++;
                $display("FAIL idle_no_load[%0d]: got b=%b valid=%b, want b=0000 valid=0", i, b, valid);
            end
        end
    endtask

    task automatic test_direct();
        logic [1:0] av [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
        logic [3:0] bv [4] = '{4'b1000, 4'b0010, 4'b0001, 4'b0100};
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b1; a = av[i];
            step();
            vec_cnt++;
            if (b !== bv[i] || valid !== 1'b1 || idx !== av[i]) begin
                miss_cnt++;
                $display("FAIL direct_load[%0d]: got b=%b idx=%0d valid=%b, want b=%b idx=%0d valid=1",
                         i, b, idx, valid, bv[i], av[i]);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 2'(i);
            step();
            vec_cnt++;
            if (b !== 4'b0100 || idx !== 2'd2 || valid !== 1'b1) begin
                miss_cnt++;
                $display("FAIL direct_hold[%0d]: got b=%b idx=%0d valid=%b, want b=0100 idx=2 valid=1",
                         i, b, idx, valid);
            end
        end
    endtask

    // Step 0 is the SCAN entry edge; each index lasts 4 steps, wrap on step 16.
    task automatic test_scan_walk();
        logic [1:0] ei;
        logic [3:0] eb;
        logic       ew;
        mode = 1'b1; load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            ei = 2'((k / 4) % 4);
            eb = 4'b0001 << ei;
            ew = (k == 16);
            vec_cnt++;
            if (b !== eb || idx !== ei || wrap !== ew || valid !== 1'b1) begin
                miss_cnt++;
                $display("FAIL scan_walk[%0d]: got b=%b idx=%0d wrap=%b valid=%b, want b=%b idx=%0d wrap=%b valid=1",
                         k, b, idx, wrap, valid, eb, ei, ew);
            end
        end
    endtask

    task automatic test_scan_reload_freeze();
        // Walk left idx=0 with dwell=3; three more edges give idx=1, dwell=2.
        for (int i = 0; i < 3; i++) step();
        vec_cnt++;
        if (idx !== 2'd1 || b !== 4'b0010) begin
            miss_cnt++;
            $display("FAIL reload_setup: got b=%b idx=%0d, want b=0010 idx=1", b, idx);
        end
        load = 1'b1; a = 2'd3;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (b !== 4'b1000 || idx !== 2'd3 || wrap !== 1'b0) begin
                miss_cnt++;
                $display("FAIL reload_dwell[%0d]: got b=%b idx=%0d wrap=%b, want b=1000 idx=3 wrap=0",
                         i, b, idx, wrap);
            end
            step();
        end
        vec_cnt++;
        if (b !== 4'b0001 || wrap !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reload_wrap: got b=%b wrap=%b, want b=0001 wrap=1", b, wrap);
        end
        en = 1'b0;
        step();
        vec_cnt++;
        if (wrap !== 1'b0 || b !== 4'b0001) begin
            miss_cnt++;
            $display("FAIL freeze_wrap_clear: got b=%b wrap=%b, want b=0001 wrap=0", b, wrap);
        end
        en = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vec_cnt++;
            if (b !== 4'b0001 || idx !== 2'd0 || wrap !== 1'b0 || valid !== 1'b1) begin
                miss_cnt++;
                $display("FAIL freeze[%0d]: got b=%b idx=%0d wrap=%b valid=%b, want b=0001 idx=0 wrap=0 valid=1",
                         i, b, idx, wrap, valid);
            end
        end
        en = 1'b1;
        // Dwell was 1 when frozen: two edges to reach 3, the third advances.
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if (b !== ((i < 2) ? 4'b0001 : 4'b0010)) begin
                miss_cnt++;
                $display("FAIL resume[%0d]: got b=%b, want b=%b", i, b, (i < 2) ? 4'b0001 : 4'b0010);
            end
        end
    endtask

    task automatic test_mode_switch_reset();
        for (int i = 0; i < 4; i++) step();
        vec_cnt++;
        if (idx !== 2'd2 || b !== 4'b0100) begin
            miss_cnt++;
            $display("FAIL switch_setup: got b=%b idx=%0d, want b=0100 idx=2", b, idx);
        end
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 2'(i);
            step();
            vec_cnt++;
            if (b !== 4'b0100 || idx !== 2'd2 || wrap !== 1'b0 || valid !== 1'b1) begin
                miss_cnt++;
                $display("FAIL switch_hold[%0d]: got b=%b idx=%0d wrap=%b valid=%b, want b=0100 idx=2 wrap=0 valid=1",
                         i, b, idx, wrap, valid);
            end
        end
        load = 1'b1; a = 2'd1;
        step();
        vec_cnt++;
        if (b !== 4'b0010) begin
            miss_cnt++;
            $display("FAIL switch_load: got b=%b, want b=0010", b);
        end
        mode = 1'b1; a = 2'd3;
        step();
        load = 1'b0;
        vec_cnt++;
        if (b !== 4'b0001 || idx !== 2'd0) begin
            miss_cnt++;
            $display("FAIL entry_load_ignored: got b=%b idx=%0d, want b=0001 idx=0", b, idx);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vec_cnt++;
        if (b !== 4'b0000 || valid !== 1'b0 || idx !== 2'd0 || wrap !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_mid_scan: got b=%b idx=%0d valid=%b wrap=%b, want b=0000 idx=0 valid=0 wrap=0",
                     b, idx, valid, wrap);
        end
    endtask

    task automatic test_active_low_scan();
        logic [2:0] ei;
        logic [7:0] eb;
        logic       ew;
        rst_n2 = 1'b0; en2 = 1'b1; mode2 = 1'b1; load2 = 1'b0; a2 = 3'd5;
        step();
        vec_cnt++;
        if (b2 !== 8'hFF || valid2 !== 1'b0 || idx2 !== 3'd0) begin
            miss_cnt++;
            $display("FAIL al_reset: got b=%b idx=%0d valid=%b, want b=11111111 idx=0 valid=0", b2, idx2, valid2);
        end
        rst_n2 = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
            ei = 3'(k % 8);
            eb = ~(8'b0000_0001 << ei);
            ew = (k > 0) && (k % 8 == 0);
            vec_cnt++;
            if (b2 !== eb || idx2 !== ei || wrap2 !== ew || valid2 !== 1'b1) begin
                miss_cnt++;
                $display("FAIL al_scan[%0d]: got b=%b idx=%0d wrap=%b valid=%b, want b=%b idx=%0d wrap=%b valid=1",
                         k, b2, idx2, wrap2, valid2, eb, ei, ew);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; a = 2'd0;
        rst_n2 = 1'b0; en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; a2 = 3'd0;
        test_reset();
        test_direct();
        test_scan_walk();
        test_scan_reload_freeze();
        test_mode_switch_reset();
        test_active_low_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
